// File: rtl/gray_bcd_converter.sv
// Handshaked binary<->Gray converter with iterative double-dabble BCD readout
// of both the accepted word and the converted word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high, waiting for a word
// CONVERT | one double-dabble step per cycle on both engines
// DONE    | out_valid high, results held until out_ready
module gray_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [4*DIGITS-1:0]   bcd_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  mode_out
);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_VALUE = (longint'(1) << WIDTH) - 1;
    localparam int     CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 16 || pow10(DIGITS) <= MAX_VALUE) begin : g_bad_params
            $error("gray_bcd_converter: WIDTH must be 2..16 and DIGITS must hold 2^WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     step;
    logic [WIDTH-1:0]  val_a;
    logic [WIDTH-1:0]  val_b;
    logic [WIDTH-1:0]  conv;
    logic [4*DIGITS-1:0] adj_a;
    logic [4*DIGITS-1:0] adj_b;

    function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] r;
        r = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Gray->binary is a running XOR from the MSB down.
    always_comb begin
        logic acc;
        conv = '0;
        acc  = 1'b0;
        if (mode) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                acc     = acc ^ data_in[i];
                conv[i] = acc;
            end
        end else begin
            conv = data_in ^ (data_in >> 1);
        end
    end

    assign adj_a    = dabble_adjust(bcd_in);
    assign adj_b    = dabble_adjust(bcd_out);
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            val_a     <= '0;
            val_b     <= '0;
            data_out  <= '0;
            bcd_in    <= '0;
            bcd_out   <= '0;
            mode_out  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        val_a    <= data_in;
                        val_b    <= conv;
                        data_out <= conv;
                        mode_out <= mode;
                        bcd_in   <= '0;
                        bcd_out  <= '0;
                        step     <= '0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_in  <= {adj_a[4*DIGITS-2:0], val_a[WIDTH-1]};
                    val_a   <= {val_a[WIDTH-2:0], 1'b0};
                    bcd_out <= {adj_b[4*DIGITS-2:0], val_b[WIDTH-1]};
                    val_b   <= {val_b[WIDTH-2:0], 1'b0};
                    step    <= step + CW'(1);
                    if (step == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_bcd_converter.sv
// Bench for gray_bcd_converter: directed table and corner sequences on an 8-bit
// instance, randomized regression on 4-bit and 12-bit instances.
module tb_gray_bcd_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0: WIDTH=8/DIGITS=3, 1: WIDTH=4/DIGITS=2, 2: WIDTH=12/DIGITS=4
    logic        iv   [3];
    logic [15:0] din  [3];
    logic        md   [3];
    logic        ordy [3];
    logic        rdy  [3];
    logic        ov   [3];
    logic [15:0] dout [3];
    logic [15:0] bi   [3];
    logic [15:0] bo   [3];
    logic        mo   [3];

    logic        rdy8, ov8, mo8, rdy4, ov4, mo4, rdy12, ov12, mo12;
    logic [7:0]  dout8;
    logic [11:0] bi8, bo8;
    logic [3:0]  dout4;
    logic [7:0]  bi4, bo4;
    logic [11:0] dout12;
    logic [15:0] bi12, bo12;

    gray_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy8), .data_in(din[0][7:0]),
        .mode(md[0]), .out_valid(ov8), .out_ready(ordy[0]), .data_out(dout8),
        .bcd_in(bi8), .bcd_out(bo8), .mode_out(mo8));

    gray_bcd_converter #(.WIDTH(4), .DIGITS(2)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy4), .data_in(din[1][3:0]),
        .mode(md[1]), .out_valid(ov4), .out_ready(ordy[1]), .data_out(dout4),
        .bcd_in(bi4), .bcd_out(bo4), .mode_out(mo4));

    gray_bcd_converter #(.WIDTH(12), .DIGITS(4)) u_w12 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy12), .data_in(din[2][11:0]),
        .mode(md[2]), .out_valid(ov12), .out_ready(ordy[2]), .data_out(dout12),
        .bcd_in(bi12), .bcd_out(bo12), .mode_out(mo12));

    assign rdy[0] = rdy8;   assign rdy[1] = rdy4;   assign rdy[2] = rdy12;
    assign ov[0]  = ov8;    assign ov[1]  = ov4;    assign ov[2]  = ov12;
    assign mo[0]  = mo8;    assign mo[1]  = mo4;    assign mo[2]  = mo12;
    assign dout[0] = 16'(dout8);  assign dout[1] = 16'(dout4);  assign dout[2] = 16'(dout12);
    assign bi[0] = 16'(bi8);      assign bi[1] = 16'(bi4);      assign bi[2] = bi12;
    assign bo[0] = 16'(bo8);      assign bo[1] = 16'(bo4);      assign bo[2] = bo12;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wid(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 12);
    endfunction

    function automatic logic [15:0] b2g(input int v, input int w);
        return 16'((v ^ (v >> 1)) & ((1 << w) - 1));
    endfunction

    // Gray->binary by searching for the binary word whose Gray code matches.
    function automatic logic [15:0] g2b(input int g, input int w);
        for (int b = 0; b < (1 << w); b++)
            if (int'(b2g(b, w)) == g) return 16'(b);
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- one full transaction ----------------
    task automatic xfer(input int k, input logic [15:0] v, input logic m, input int stall,
                        input logic [15:0] ed, input logic [15:0] ebi, input logic [15:0] ebo,
                        output logic [15:0] ad);
        int g;
        int lat;
        string tag;
        tag = $sformatf("w%0d v=%0h m=%0d", wid(k), v, m);
        g = 0;
        while (!rdy[k] && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk({tag, " in_ready idle"}, 32'(rdy[k]), 1);
        iv[k] = 1'b1; din[k] = v; md[k] = m;
        @(posedge clk); #1;
        iv[k] = 1'b0; md[k] = ~m; din[k] = 16'($urandom);
        chk({tag, " in_ready busy"}, 32'(rdy[k]), 0);
        lat = 0;
        while (!ov[k] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, lat, wid(k));
        ad = dout[k];
        for (int s = 0; s <= stall; s++) begin
            chk({tag, " out_valid"}, 32'(ov[k]), 1);
            chk({tag, " data_out"}, dout[k], ed);
            chk({tag, " bcd_in"}, bi[k], ebi);
            chk({tag, " bcd_out"}, bo[k], ebo);
            chk({tag, " mode_out"}, 32'(mo[k]), 32'(m));
            chk({tag, " in_ready done"}, 32'(rdy[k]), 0);
            if (s < stall) begin
                @(posedge clk); #1;
            end
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk({tag, " out_valid after xfer"}, 32'(ov[k]), 0);
        chk({tag, " in_ready after xfer"}, 32'(rdy[k]), 1);
    endtask

    task automatic rand_run(input int k, input int n);
        int w;
        logic [15:0] v, d, act, g, rb;
        logic m;
        w = wid(k);
        for (int it = 0; it < n; it++) begin
            v = 16'($urandom_range(0, (1 << w) - 1));
            m = 1'($urandom);
            d = m ? g2b(int'(v), w) : b2g(int'(v), w);
            xfer(k, v, m, $urandom_range(0, 3), d, bcd(int'(v)), bcd(int'(d)), act);
            if (it % 4 == 0) begin
                g = b2g(int'(v), w);
                xfer(k, v, 1'b0, 0, g, bcd(int'(v)), bcd(int'(g)), act);
                xfer(k, act, 1'b1, 0, v, bcd(int'(act)), bcd(int'(v)), rb);
                chk($sformatf("w%0d roundtrip %0h", w, v), rb, v);
            end
        end
    endtask

    typedef struct {
        logic        m;
        logic [15:0] v;
        logic [15:0] d;
        logic [15:0] ebi;
        logic [15:0] ebo;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] act;
        int lat;
        logic rose;

        tbl[0] = '{1'b0, 16'd200,  16'hAC,  16'h0200, 16'h0172};
        tbl[1] = '{1'b1, 16'hAC,   16'd200, 16'h0172, 16'h0200};
        tbl[2] = '{1'b0, 16'd255,  16'd128, 16'h0255, 16'h0128};
        tbl[3] = '{1'b0, 16'd0,    16'd0,   16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 16'd0,    16'd0,   16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 16'h80,   16'd255, 16'h0128, 16'h0255};
        tbl[6] = '{1'b1, 16'hFF,   16'hAA,  16'h0255, 16'h0170};

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; din[k] = '0; md[k] = 1'b0; ordy[k] = 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(rdy[0]), 0);
        chk("reset out_valid", 32'(ov[0]), 0);
        chk("reset data_out", dout[0], 0);
        chk("reset bcd_in", bi[0], 0);
        chk("reset bcd_out", bo[0], 0);
        chk("reset mode_out", 32'(mo[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset w8", 32'(rdy[0]), 1);
        chk("in_ready after reset w4", 32'(rdy[1]), 1);
        chk("in_ready after reset w12", 32'(rdy[2]), 1);

        // directed table
        for (int i = 0; i < 7; i++)
            xfer(0, tbl[i].v, tbl[i].m, i % 3, tbl[i].d, tbl[i].ebi, tbl[i].ebo, act);

        // backpressure with in_valid held high through DONE
        iv[0] = 1'b1; din[0] = 16'd200; md[0] = 1'b0;
        @(posedge clk); #1;
        din[0] = 16'd55; md[0] = 1'b1;
        lat = 0;
        while (!ov[0] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp latency", lat, 8);
        for (int s = 0; s < 5; s++) begin
            chk("bp hold out_valid", 32'(ov[0]), 1);
            chk("bp hold data_out", dout[0], 16'hAC);
            chk("bp hold bcd_in", bi[0], 16'h0200);
            chk("bp hold bcd_out", bo[0], 16'h0172);
            chk("bp hold mode_out", 32'(mo[0]), 0);
            chk("bp hold in_ready", 32'(rdy[0]), 0);
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp out_valid after xfer", 32'(ov[0]), 0);
        chk("bp in_ready after xfer", 32'(rdy[0]), 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp held word accepted", 32'(rdy[0]), 0);
        lat = 0;
        while (!ov[0] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp second latency", lat, 8);
        chk("bp second data_out", dout[0], g2b(55, 8));
        chk("bp second bcd_in", bi[0], 16'h0055);
        chk("bp second bcd_out", bo[0], bcd(int'(g2b(55, 8))));
        chk("bp second mode_out", 32'(mo[0]), 1);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;

        // reset in the middle of CONVERT
        iv[0] = 1'b1; din[0] = 16'd200; md[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset out_valid", 32'(ov[0]), 0);
        chk("midreset data_out", dout[0], 0);
        chk("midreset bcd_in", bi[0], 0);
        chk("midreset bcd_out", bo[0], 0);
        chk("midreset mode_out", 32'(mo[0]), 0);
        chk("midreset in_ready", 32'(rdy[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rose = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov[0]) rose = 1'b1;
        end
        chk("midreset no stale result", 32'(rose), 0);
        xfer(0, 16'd37, 1'b0, 1, 16'd55, 16'h0037, 16'h0055, act);

        // randomized regression on the narrow and wide instances
        fork
            rand_run(1, 40);
            rand_run(2, 40);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
